// File: rtl/gcd_pkg.sv
// Shared types and helpers for the streaming binary-GCD engine.
package gcd_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REDUCE = 2'd1,
    DONE   = 2'd2
  } gcd_state_e;

  // Worst case is 2*DATA_WIDTH+1 reduce cycles, so this width never saturates in practice.
  function automatic int unsigned gcd_cnt_width(input int unsigned data_width);
    return $clog2(2 * data_width + 2);
  endfunction

endpackage

// File: rtl/gcd_stein_step.sv
// One combinational step of the binary (Stein) GCD reduction.
module gcd_stein_step #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned K_WIDTH    = 4
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic [K_WIDTH-1:0]    k,
  output logic [DATA_WIDTH-1:0] a_next,
  output logic [DATA_WIDTH-1:0] b_next,
  output logic [K_WIDTH-1:0]    k_next,
  output logic                  done
);

  always_comb begin
    a_next = a;
    b_next = b;
    k_next = k;
    done   = 1'b0;
    if (a == '0 || b == '0) begin
      done = 1'b1;
    end else if (!a[0] && !b[0]) begin
      a_next = a >> 1;
      b_next = b >> 1;
      k_next = k + K_WIDTH'(1);
    end else if (!a[0]) begin
      a_next = a >> 1;
    end else if (!b[0]) begin
      b_next = b >> 1;
    end else if (a >= b) begin
      // Both odd: the difference is even, so halving it keeps one step per cycle.
      a_next = (a - b) >> 1;
    end else begin
      b_next = (b - a) >> 1;
    end
  end

endmodule

// File: rtl/gcd_stream_engine.sv
// Streaming binary-GCD engine with valid/ready request and result handshakes.
// Optional reduce-cycle counter on cycles_o when GCD_STREAM_CYCLES_EN is defined.
module gcd_stream_engine
  import gcd_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH = 16,
  parameter  int unsigned TAG_WIDTH  = 4,
  localparam int unsigned CNT_WIDTH  = gcd_cnt_width(DATA_WIDTH)
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [DATA_WIDTH-1:0] operand_a_i,
  input  logic [DATA_WIDTH-1:0] operand_b_i,
  input  logic [TAG_WIDTH-1:0]  tag_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DATA_WIDTH-1:0] gcd_o,
  output logic [TAG_WIDTH-1:0]  tag_o,
  output logic [CNT_WIDTH-1:0]  cycles_o
);

  localparam int unsigned K_WIDTH = $clog2(DATA_WIDTH);

  gcd_state_e            state_q;
  logic [DATA_WIDTH-1:0] a_q, b_q, gcd_q;
  logic [K_WIDTH-1:0]    k_q;
  logic [TAG_WIDTH-1:0]  tag_q;

  logic [DATA_WIDTH-1:0] a_next, b_next;
  logic [K_WIDTH-1:0]    k_next;
  logic                  done;

  gcd_stein_step #(
    .DATA_WIDTH (DATA_WIDTH),
    .K_WIDTH    (K_WIDTH)
  ) u_step (
    .a      (a_q),
    .b      (b_q),
    .k      (k_q),
    .a_next (a_next),
    .b_next (b_next),
    .k_next (k_next),
    .done   (done)
  );

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      k_q     <= '0;
      tag_q   <= '0;
      gcd_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid_i) begin
            a_q     <= operand_a_i;
            b_q     <= operand_b_i;
            k_q     <= '0;
            tag_q   <= tag_i;
            state_q <= REDUCE;
          end
        end
        REDUCE: begin
          if (done) begin
            gcd_q   <= (a_q | b_q) << k_q;
            state_q <= DONE;
          end else begin
            a_q <= a_next;
            b_q <= b_next;
            k_q <= k_next;
          end
        end
        DONE: begin
          if (out_ready_i) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Pure decodes of the state register, so no input reaches an output combinationally.
  always_comb begin
    in_ready_o  = (state_q == IDLE);
    out_valid_o = (state_q == DONE);
    gcd_o       = gcd_q;
    tag_o       = tag_q;
  end

`ifdef GCD_STREAM_CYCLES_EN
  logic [CNT_WIDTH-1:0] cnt_q, cnt_inc, cycles_q;

  always_comb begin
    cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNT_WIDTH'(1);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cnt_q    <= '0;
      cycles_q <= '0;
    end else if (state_q == IDLE && in_valid_i) begin
      cnt_q <= '0;
    end else if (state_q == REDUCE) begin
      cnt_q <= cnt_inc;
      if (done) begin
        cycles_q <= cnt_inc;
      end
    end
  end

  always_comb begin
    cycles_o = cycles_q;
  end
`else
  always_comb begin
    cycles_o = '0;
  end
`endif

endmodule

// File: tb/tb_gcd_stream_engine.sv
// Self-checking bench for gcd_stream_engine: directed table, reset/back-pressure sequences, random stream.
module tb_gcd_stream_engine;

  localparam int unsigned DW = 16;
  localparam int unsigned TW = 4;
  localparam int unsigned CW = $clog2(2 * DW + 2);

  logic          clk_i = 1'b0;
  logic          reset_i;
  logic          in_valid_i;
  logic          in_ready_o;
  logic [DW-1:0] operand_a_i;
  logic [DW-1:0] operand_b_i;
  logic [TW-1:0] tag_i;
  logic          out_valid_o;
  logic          out_ready_i;
  logic [DW-1:0] gcd_o;
  logic [TW-1:0] tag_o;
  logic [CW-1:0] cycles_o;

  int vectors = 0;
  int miscompares = 0;

  gcd_stream_engine #(
    .DATA_WIDTH (DW),
    .TAG_WIDTH  (TW)
  ) dut (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .operand_a_i (operand_a_i),
    .operand_b_i (operand_b_i),
    .tag_i       (tag_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .gcd_o       (gcd_o),
    .tag_o       (tag_o),
    .cycles_o    (cycles_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int unsigned a;
    int unsigned b;
    int unsigned tag;
    int unsigned gcd;
    int unsigned n;     // 0: not fixed by hand, bounded by 2*DW+1 instead
  } vec_t;

  typedef struct {
    int unsigned gcd;
    int unsigned tag;
    int unsigned n;
  } exp_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int unsigned ref_gcd(input int unsigned a, input int unsigned b);
    int unsigned t;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  // Number of reduce cycles the binary algorithm needs, terminating cycle included.
  function automatic int unsigned ref_steps(input int unsigned a, input int unsigned b);
    int unsigned n = 1;
    while (a != 0 && b != 0) begin
      if (a % 2 == 0 && b % 2 == 0) begin a = a / 2; b = b / 2; end
      else if (a % 2 == 0) a = a / 2;
      else if (b % 2 == 0) b = b / 2;
      else if (a >= b) a = (a - b) / 2;
      else b = (b - a) / 2;
      n++;
    end
    return n;
  endfunction

  function automatic int unsigned exp_cycles(input int unsigned n);
`ifdef GCD_STREAM_CYCLES_EN
    return n;
`else
    return 0;
`endif
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic start_and_wait(input int unsigned a, input int unsigned b,
                                input int unsigned t, output int lat);
    int guard = 0;
    while (!in_ready_o && guard < 200) begin tick(); guard++; end
    if (!in_ready_o) check("accept_timeout", 32'(in_ready_o), 1);
    in_valid_i  = 1'b1;
    operand_a_i = DW'(a);
    operand_b_i = DW'(b);
    tag_i       = TW'(t);
    tick();
    in_valid_i = 1'b0;
    lat = 0;
    while (!out_valid_o && lat < 100) begin tick(); lat++; end
    if (!out_valid_o) check("result_timeout", 32'(out_valid_o), 1);
  endtask

  vec_t vecs[7];
  exp_t q[$];

  initial begin
    int lat;
    int unsigned n;
    vecs[0] = '{a: 48,    b: 18,    tag: 5,  gcd: 6,     n: 7};
    vecs[1] = '{a: 0,     b: 0,     tag: 1,  gcd: 0,     n: 1};
    vecs[2] = '{a: 0,     b: 7,     tag: 2,  gcd: 7,     n: 1};
    vecs[3] = '{a: 9,     b: 0,     tag: 3,  gcd: 9,     n: 1};
    vecs[4] = '{a: 65535, b: 65535, tag: 4,  gcd: 65535, n: 2};
    vecs[5] = '{a: 32768, b: 16384, tag: 6,  gcd: 16384, n: 17};
    vecs[6] = '{a: 65521, b: 65519, tag: 7,  gcd: 1,     n: 0};

    reset_i = 1'b1; in_valid_i = 1'b0; out_ready_i = 1'b0;
    operand_a_i = '0; operand_b_i = '0; tag_i = '0;
    #2;
    check("reset_in_ready", 32'(in_ready_o), 1);
    check("reset_out_valid", 32'(out_valid_o), 0);
    check("reset_gcd", 32'(gcd_o), 0);
    check("reset_tag", 32'(tag_o), 0);
    check("reset_cycles", 32'(cycles_o), 0);
    #15 reset_i = 1'b0;

    // Directed table, consumer always ready.
    out_ready_i = 1'b1;
    foreach (vecs[i]) begin
      n = ref_steps(vecs[i].a, vecs[i].b);
      start_and_wait(vecs[i].a, vecs[i].b, vecs[i].tag, lat);
      check("tbl_gcd", 32'(gcd_o), vecs[i].gcd);
      check("tbl_tag", 32'(tag_o), vecs[i].tag);
      check("tbl_latency", 32'(lat), n);
      check("tbl_cycles", 32'(cycles_o), exp_cycles(n));
      if (vecs[i].n != 0) check("tbl_latency_hand", 32'(lat), vecs[i].n);
      else check("tbl_latency_bound", 32'(lat <= 2 * DW + 1), 1);
      tick();
      check("tbl_post_ready", 32'(in_ready_o), 1);
      check("tbl_post_valid", 32'(out_valid_o), 0);
    end

    // Asynchronous reset in the middle of a long reduction.
    in_valid_i = 1'b1; operand_a_i = 16'd32768; operand_b_i = 16'd16384; tag_i = 4'd11;
    tick();
    in_valid_i = 1'b0;
    repeat (5) tick();
    check("pre_reset_busy", 32'(in_ready_o), 0);
    #2 reset_i = 1'b1;
    #1;
    check("areset_in_ready", 32'(in_ready_o), 1);
    check("areset_out_valid", 32'(out_valid_o), 0);
    check("areset_gcd", 32'(gcd_o), 0);
    check("areset_tag", 32'(tag_o), 0);
    check("areset_cycles", 32'(cycles_o), 0);
    #3 reset_i = 1'b0;
    start_and_wait(48, 18, 5, lat);
    check("after_reset_gcd", 32'(gcd_o), 6);
    check("after_reset_tag", 32'(tag_o), 5);
    check("after_reset_latency", 32'(lat), 7);
    check("after_reset_cycles", 32'(cycles_o), exp_cycles(7));
    tick();

    // Back-pressure with a second request held during DONE.
    out_ready_i = 1'b0;
    start_and_wait(48, 18, 9, lat);
    in_valid_i = 1'b1; operand_a_i = 16'd0; operand_b_i = 16'd7; tag_i = 4'd10;
    for (int c = 0; c < 10; c++) begin
      check("bp_valid", 32'(out_valid_o), 1);
      check("bp_in_ready", 32'(in_ready_o), 0);
      check("bp_gcd", 32'(gcd_o), 6);
      check("bp_tag", 32'(tag_o), 9);
      check("bp_cycles", 32'(cycles_o), exp_cycles(7));
      tick();
    end
    out_ready_i = 1'b1;
    tick();
    out_ready_i = 1'b0;
    check("bp_handshake_ready", 32'(in_ready_o), 1);
    check("bp_handshake_valid", 32'(out_valid_o), 0);
    tick();
    in_valid_i = 1'b0;
    check("bp_second_accepted", 32'(in_ready_o), 0);
    lat = 0;
    while (!out_valid_o && lat < 100) begin tick(); lat++; end
    check("bp_second_latency", 32'(lat), 1);
    check("bp_second_gcd", 32'(gcd_o), 7);
    check("bp_second_tag", 32'(tag_o), 10);
    out_ready_i = 1'b1;
    tick();

    // Random stream with random valid/ready, checked in order against the reference.
    begin
      int unsigned sent = 0, recv = 0, cyc = 0;
      int unsigned pa, pb, f;
      exp_t e;
      pa = $urandom_range(0, 65535); pb = $urandom_range(0, 65535);
      while (recv < 1000 && cyc < 80000) begin
        if (out_valid_o && out_ready_i) begin
          if (q.size() == 0) begin
            check("rnd_unexpected_result", 32'(out_valid_o), 0);
          end else begin
            e = q.pop_front();
            check("rnd_gcd", 32'(gcd_o), e.gcd);
            check("rnd_tag", 32'(tag_o), e.tag);
            check("rnd_cycles", 32'(cycles_o), exp_cycles(e.n));
          end
          recv++;
        end
        if (in_valid_i && in_ready_o) begin
          e.gcd = ref_gcd(pa, pb);
          e.tag = sent % 16;
          e.n   = ref_steps(pa, pb);
          q.push_back(e);
          sent++;
          case ($urandom_range(0, 3))
            0: begin pa = $urandom_range(0, 15); pb = $urandom_range(0, 15); end
            1: begin
              f  = $urandom_range(1, 255);
              pa = (f * $urandom_range(0, 255)) & 32'hFFFF;
              pb = (f * $urandom_range(0, 255)) & 32'hFFFF;
            end
            2: begin pa = $urandom_range(0, 65535) << $urandom_range(0, 8); pa &= 32'hFFFF;
                     pb = $urandom_range(0, 65535); end
            default: begin pa = $urandom_range(0, 65535); pb = $urandom_range(0, 65535); end
          endcase
        end
        @(posedge clk_i);
        #1;
        cyc++;
        in_valid_i  = (sent < 1000) && ($urandom_range(0, 3) != 0);
        operand_a_i = DW'(pa);
        operand_b_i = DW'(pb);
        tag_i       = TW'(sent % 16);
        out_ready_i = ($urandom_range(0, 2) != 0);
      end
      check("rnd_all_received", recv, 1000);
      in_valid_i = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/gcd_stream_engine.md
# gcd_stream_engine

Parametrised, streaming successor to the single-shot GCD core: accepts operand pairs over a valid/ready input handshake and computes the greatest common divisor with the binary (Stein) algorithm. Each result is returned with a user tag over a valid/ready output handshake that tolerates back-pressure. It sits between a request producer and a result consumer in the same clock domain, so no enable synchroniser is needed.

## Interface
- DATA_WIDTH, 16, operand/result width in bits (≥2)
- TAG_WIDTH, 4, width of the pass-through request tag (≥1)
- CNT_WIDTH, $clog2(2*DATA_WIDTH+2), width of cycles_o (derived, not overridden)

- clk_i  in  1  single clock, rising edge
- reset_i  in  1  asynchronous, active-high reset
- in_valid_i  in  1  operand pair valid
- in_ready_o  out  1  engine can accept a pair
- operand_a_i  in  DATA_WIDTH  first operand, unsigned
- operand_b_i  in  DATA_WIDTH  second operand, unsigned
- tag_i  in  TAG_WIDTH  request tag
- out_valid_o  out  1  result valid
- out_ready_i  in  1  consumer accepts result
- gcd_o  out  DATA_WIDTH  gcd(a,b); gcd(0,0)=0
- tag_o  out  TAG_WIDTH  tag of the request that produced gcd_o
- cycles_o  out  CNT_WIDTH  REDUCE cycles spent on this result (see Configuration)

## Operation
- States: IDLE, REDUCE, DONE.
- IDLE: in_ready_o=1. On in_valid_i && in_ready_o: latch a, b, tag; clear shift count k and cycle counter; go to REDUCE.
- REDUCE: one step per cycle, evaluated in this priority order:
  - a==0 or b==0: gcd_o ← (a|b)<<k; go to DONE.
  - both even: a>>=1, b>>=1, k++.
  - a even: a>>=1.
  - b even: b>>=1.
  - both odd, a≥b: a ← (a−b)>>1.
  - both odd, a<b: b ← (b−a)>>1.
- The cycle counter increments on every REDUCE cycle, including the terminating one.
- k never exceeds DATA_WIDTH−1.
- Subtraction is performed only on the larger operand, so no borrow occurs.
- The shifted result always fits DATA_WIDTH bits.
- DONE: out_valid_o=1; gcd_o, tag_o and cycles_o are held stable until out_valid_o && out_ready_i, then the engine returns to IDLE.
- in_ready_o=0 in REDUCE and DONE. One request is in flight at a time. Inputs presented then are ignored, not queued.
- in_valid_i dropping while in_ready_o=0 has no effect.

## Timing
- Reset (asynchronous, any state) forces:
  - state=IDLE, in_ready_o=1, out_valid_o=0
  - gcd_o=0, tag_o=0, cycles_o=0
- A result in flight is discarded by reset.
- The first handshake is possible in the first cycle after reset deasserts.
- Latency: with the accept edge at t0 and N REDUCE cycles, out_valid_o rises after edge t0+N.
- N = 1 when either operand is 0.
- Worst case N ≤ 2*DATA_WIDTH+1.
- Result handshake at edge t: in_ready_o=1 after t. The next accept is at t+1 at the earliest, so a one-cycle bubble exists by design.
- out_ready_i may be held high in advance; the result then transfers on the first DONE cycle.
- All outputs are registered, with no combinational input-to-output path.

## Configuration
- GCD_STREAM_CYCLES_EN defined:
  - cycle counter synthesised
  - cycles_o reports N, captured on entry to DONE
  - counter saturates at all-ones
- Not defined:
  - counter not built
  - cycles_o tied to 0
  - port kept, so instantiations are identical in both builds

## Structure
- gcd_pkg holds:
  - gcd_state_e enum (IDLE, REDUCE, DONE)
  - a localparam helper function computing CNT_WIDTH from DATA_WIDTH
- Sub-module gcd_stein_step (combinational, DATA_WIDTH parametrised):
  - takes a, b, k
  - returns next a, b, k and a done flag
  - instantiated once inside gcd_stream_engine, which owns the FSM, registers and handshakes

## Test plan
- Reset (DATA_WIDTH=16):
  - Assert reset_i asynchronously mid-REDUCE -> all outputs return to reset values immediately; the next request completes correctly.
- (48,18), tag 5, out_ready_i=1 -> gcd_o=6, tag_o=5, cycles_o=7 (with macro), out_valid_o rises 7 cycles after accept.
- Zero operands:
  - (0,0) -> 0
  - (0,7) -> 7
  - (9,0) -> 9
  - each with cycles_o=1
- Extremes:
  - (65535,65535) -> 65535
  - (32768,16384) -> 16384
  - (65521,65519) -> 1, checked against the ≤33-cycle bound
- Back-pressure:
  - out_ready_i low for 10 cycles in DONE -> outputs stable and in_ready_o=0 throughout; a second request held during that time is accepted one cycle after the result handshake.
- Random stream of 1000 pairs with random in_valid_i/out_ready_i -> every result matches the reference gcd and tag order is preserved.
